// File: rtl/ram_block_copy_pkg.sv
// Shared constants and types for the RAM block-copy master.
package ram_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 10;

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_e;
  typedef enum logic {ASC, DESC} dir_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] src;
    logic [ADDR_WIDTH-1:0] dst;
    logic [ADDR_WIDTH:0]   len;
    dir_e                  dir;
  } copy_req_t;
endpackage

// File: rtl/ram_block_copy_if.sv
// Control request/status plus both RAM ports of the copy master.
interface ram_block_copy_if;
  import ram_pkg::*;

  logic                  start;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [ADDR_WIDTH-1:0] dst_addr;
  logic [ADDR_WIDTH:0]   len;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic                  we_a;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] q_a_out;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic                  we_b;
  logic [DATA_WIDTH-1:0] data_b;

  modport master (
    input  start, src_addr, dst_addr, len, q_a_out,
    output busy, done, addr_a, we_a, data_a, addr_b, we_b, data_b
  );

  modport slave (
    output start, src_addr, dst_addr, len, q_a_out,
    input  busy, done, addr_a, we_a, data_a, addr_b, we_b, data_b
  );
endinterface

// File: rtl/ram_block_copy_addr_gen.sv
// Wrapped word address for copy index i, ascending or descending from base.
module ram_copy_addr_gen
  import ram_pkg::*;
#(
  parameter int AW = ADDR_WIDTH
) (
  input  logic [AW-1:0] i_base,
  input  logic [AW-1:0] i_len,   // len mod 2^AW; enough for wrapped math
  input  dir_e          i_dir,
  input  logic [AW-1:0] i_idx,
  output logic [AW-1:0] o_addr
);
  always_comb begin
    if (i_dir == DESC) o_addr = i_base + i_len - AW'(1) - i_idx;
    else               o_addr = i_base + i_idx;
  end
endmodule

// File: rtl/ram_block_copy.sv
// Block copy inside one dual-port RAM: port A reads, port B writes one cycle later.
module ram_block_copy
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  ram_block_copy_if.master  bus
);
  localparam int AW = ADDR_WIDTH;

  state_e         r_state, w_state_nxt;
  copy_req_t      r_req, w_req;
  logic [AW-1:0]  r_idx, r_addr_a, r_addr_b;
  logic           r_we_b;
  logic [AW-1:0]  w_diff, w_src_base, w_src_len, w_src_idx, w_src_addr, w_dst_addr;
  dir_e           w_src_dir;
  logic           w_last;

  // Overlap where dst lies ahead of src within the block must copy from the top down.
  assign w_diff = bus.dst_addr - bus.src_addr;
  always_comb begin
    w_req.src = bus.src_addr;
    w_req.dst = bus.dst_addr;
    w_req.len = bus.len;
    w_req.dir = (w_diff != '0 && {1'b0, w_diff} < bus.len) ? DESC : ASC;
  end

  // In IDLE the first read address comes straight from the request inputs.
  always_comb begin
    if (r_state == IDLE) begin
      w_src_base = w_req.src;
      w_src_len  = w_req.len[AW-1:0];
      w_src_dir  = w_req.dir;
      w_src_idx  = '0;
    end else begin
      w_src_base = r_req.src;
      w_src_len  = r_req.len[AW-1:0];
      w_src_dir  = r_req.dir;
      w_src_idx  = r_idx + AW'(1);
    end
  end

  assign w_last = ({1'b0, r_idx} == r_req.len - (AW+1)'(1));

  ram_copy_addr_gen #(.AW(AW)) u_src_gen (
    .i_base (w_src_base),
    .i_len  (w_src_len),
    .i_dir  (w_src_dir),
    .i_idx  (w_src_idx),
    .o_addr (w_src_addr)
  );

  ram_copy_addr_gen #(.AW(AW)) u_dst_gen (
    .i_base (r_req.dst),
    .i_len  (r_req.len[AW-1:0]),
    .i_dir  (r_req.dir),
    .i_idx  (r_idx),
    .o_addr (w_dst_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_req    <= '0;
      r_idx    <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_we_b   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we_b  <= (r_state == READ);
      case (r_state)
        IDLE: if (bus.start && bus.len != '0) begin
          r_req    <= w_req;
          r_idx    <= '0;
          r_addr_a <= w_src_addr;
        end
        READ: begin
          r_addr_b <= w_dst_addr;
          if (!w_last) begin
            r_idx    <= r_idx + AW'(1);
            r_addr_a <= w_src_addr;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    unique case (r_state)
      IDLE:  if (bus.start) w_state_nxt = (bus.len == '0) ? DONE : READ;
      READ:  begin bus.busy = 1'b1; if (w_last) w_state_nxt = FLUSH; end
      FLUSH: begin bus.busy = 1'b1; w_state_nxt = DONE; end
      DONE:  begin bus.done = 1'b1; w_state_nxt = IDLE; end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.addr_a = r_addr_a;
  assign bus.we_a   = 1'b0;
  assign bus.data_a = '0;
  assign bus.addr_b = r_addr_b;
  assign bus.we_b   = r_we_b;
  assign bus.data_b = r_we_b ? bus.q_a_out : '0;
endmodule

// File: tb/tb_ram_block_copy.sv
// Directed bench: behavioural RAM model around ram_block_copy, hand-computed results.
module tb_ram_block_copy;
  logic clk;
  logic rst_n;
  ram_block_copy_if bus ();

  ram_block_copy dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [15:0] mem [1024];
  logic        pl_we;
  logic [9:0]  pl_addr;
  logic [15:0] pl_data;

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_we)          mem[pl_addr]    <= pl_data;
    else if (bus.we_b)  mem[bus.addr_b] <= bus.data_b;
    bus.q_a_out <= mem[bus.addr_a];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [15:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic run_copy(input logic [9:0] s, input logic [9:0] d, input logic [10:0] l,
                          input bit poke_busy, output int cyc, output int wecnt,
                          output logic [9:0] first_a);
    bus.start = 1'b1; bus.src_addr = s; bus.dst_addr = d; bus.len = l;
    @(negedge clk);
    bus.start = 1'b0;
    bus.src_addr = 10'($urandom); bus.dst_addr = 10'($urandom); bus.len = 11'($urandom);
    cyc = 1; wecnt = 0; first_a = bus.addr_a;
    while (!bus.done && cyc < 2000) begin
      if (bus.we_b) wecnt++;
      if (poke_busy && cyc == 2) begin
        bus.start = 1'b1; bus.src_addr = 10'd100; bus.dst_addr = 10'd700; bus.len = 11'd3;
      end else bus.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk("we_b_in_done", {31'd0, bus.we_b}, 32'd0);
    chk("data_b_gated", {16'd0, bus.data_b}, 32'd0);
    if (poke_busy) begin
      bus.start = 1'b1; bus.src_addr = 10'd13; bus.dst_addr = 10'd710; bus.len = 11'd2;
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_after_done_start", {31'd0, bus.busy}, 32'd0);
      chk("done_single", {31'd0, bus.done}, 32'd0);
    end else @(negedge clk);
  endtask

  int cyc, wecnt;
  logic [9:0] fa;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.len = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   {31'd0, bus.busy},   32'd0);
    chk("rst_done",   {31'd0, bus.done},   32'd0);
    chk("rst_addr_a", {22'd0, bus.addr_a}, 32'd0);
    chk("rst_addr_b", {22'd0, bus.addr_b}, 32'd0);
    chk("rst_we_b",   {31'd0, bus.we_b},   32'd0);
    chk("rst_we_a",   {31'd0, bus.we_a},   32'd0);
    chk("rst_data_a", {16'd0, bus.data_a}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic copy
    for (int i = 0; i < 4; i++) poke(10'(13 + i), 16'(3 + i));
    run_copy(10'd13, 10'd47, 11'd4, 1'b0, cyc, wecnt, fa);
    chk("basic_latency", cyc, 6);
    chk("basic_we_cnt", wecnt, 4);
    chk("basic_first_a", {22'd0, fa}, 13);
    for (int i = 0; i < 4; i++) chk("basic_data", {16'd0, mem[47 + i]}, 32'(3 + i));

    // forward overlap -> descending
    for (int i = 0; i < 5; i++) poke(10'(100 + i), 16'(1 + i));
    run_copy(10'd100, 10'd102, 11'd5, 1'b0, cyc, wecnt, fa);
    chk("fwd_first_a", {22'd0, fa}, 104);
    chk("fwd_latency", cyc, 7);
    for (int i = 0; i < 5; i++) chk("fwd_data", {16'd0, mem[102 + i]}, 32'(1 + i));

    // backward overlap -> ascending
    poke(10'd200, 16'd9); poke(10'd201, 16'd8); poke(10'd202, 16'd7); poke(10'd203, 16'd6);
    run_copy(10'd200, 10'd199, 11'd4, 1'b0, cyc, wecnt, fa);
    chk("bwd_first_a", {22'd0, fa}, 200);
    for (int i = 0; i < 4; i++) chk("bwd_data", {16'd0, mem[199 + i]}, 32'(9 - i));
    chk("bwd_tail", {16'd0, mem[203]}, 6);

    // source wraps past the top of memory
    poke(10'd1022, 16'd43); poke(10'd1023, 16'd44); poke(10'd0, 16'd45); poke(10'd1, 16'd46);
    run_copy(10'd1022, 10'd500, 11'd4, 1'b0, cyc, wecnt, fa);
    for (int i = 0; i < 4; i++) chk("wrap_src_data", {16'd0, mem[500 + i]}, 32'(43 + i));
    // destination wraps
    run_copy(10'd500, 10'd1023, 11'd2, 1'b0, cyc, wecnt, fa);
    chk("wrap_dst_1023", {16'd0, mem[1023]}, 43);
    chk("wrap_dst_0",    {16'd0, mem[0]},    44);
    chk("wrap_dst_1",    {16'd0, mem[1]},    46);

    // len = 0
    run_copy(10'd5, 10'd6, 11'd0, 1'b0, cyc, wecnt, fa);
    chk("len0_latency", cyc, 1);
    chk("len0_we_cnt", wecnt, 0);

    // start while busy and while in DONE is ignored
    poke(10'd700, 16'hBEEF);
    poke(10'd710, 16'hCAFE);
    run_copy(10'd13, 10'd600, 11'd4, 1'b1, cyc, wecnt, fa);
    chk("busy_latency", cyc, 6);
    chk("busy_we_cnt", wecnt, 4);
    for (int i = 0; i < 4; i++) chk("busy_data", {16'd0, mem[600 + i]}, 32'(3 + i));
    chk("busy_ignored_700", {16'd0, mem[700]}, 32'hBEEF);
    chk("done_ignored_710", {16'd0, mem[710]}, 32'hCAFE);

    // src == dst rewrites identical data
    run_copy(10'd13, 10'd13, 11'd4, 1'b0, cyc, wecnt, fa);
    chk("same_we_cnt", wecnt, 4);
    for (int i = 0; i < 4; i++) chk("same_data", {16'd0, mem[13 + i]}, 32'(3 + i));

    // reset in READ cycle 3 of an 8-word copy
    for (int i = 0; i < 8; i++) poke(10'(300 + i), 16'(16'h11 + i));
    for (int i = 0; i < 4; i++) poke(10'(800 + i), 16'hAAAA);
    bus.start = 1'b1; bus.src_addr = 10'd300; bus.dst_addr = 10'd800; bus.len = 11'd8;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_we_b_before", {31'd0, bus.we_b}, 1);
    chk("mid_addr_a", {22'd0, bus.addr_a}, 303);
    rst_n = 1'b0;
    #1;
    chk("mid_we_b_async", {31'd0, bus.we_b}, 0);
    chk("mid_busy_async", {31'd0, bus.busy}, 0);
    @(negedge clk);
    chk("mid_no_done", {31'd0, bus.done}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_dst0", {16'd0, mem[800]}, 32'h11);
    chk("mid_dst1", {16'd0, mem[801]}, 32'h12);
    chk("mid_dst2", {16'd0, mem[802]}, 32'hAAAA);
    chk("mid_dst3", {16'd0, mem[803]}, 32'hAAAA);

    run_copy(10'd13, 10'd900, 11'd4, 1'b0, cyc, wecnt, fa);
    chk("post_rst_latency", cyc, 6);
    for (int i = 0; i < 4; i++) chk("post_rst_data", {16'd0, mem[900 + i]}, 32'(3 + i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ram_block_copy.md
Name: ram_block_copy

Overview:
- Initiator-side master for the dual-port RAM (16-bit data, 10-bit address, one write-enable per port, single clock).
- Copies a block of `len` words from `src_addr` to `dst_addr` inside the same RAM. Port A is used only for reads; port B is used only for writes.
- Throughput is one word per clock. Overlapping regions are copied correctly because the copy direction is chosen automatically.
- Sits between the CPU/control datapath and the RAM ports it drives.

Parameters:
- DATA_WIDTH, 16, RAM word width.
- ADDR_WIDTH, 10, RAM address width; the address space is 2^ADDR_WIDTH words.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- src_addr  in  ADDR_WIDTH  first source word.
- dst_addr  in  ADDR_WIDTH  first destination word.
- len  in  ADDR_WIDTH+1  word count, 0 to 2^ADDR_WIDTH.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the copy completes.
- addr_a  out  ADDR_WIDTH  RAM port A address (read).
- we_a  out  1  RAM port A write enable; constant 0.
- data_a  out  DATA_WIDTH  RAM port A write data; constant 0.
- q_a_out  in  DATA_WIDTH  RAM port A read data.
- addr_b  out  ADDR_WIDTH  RAM port B address (write).
- we_b  out  1  RAM port B write enable.
- data_b  out  DATA_WIDTH  RAM port B write data.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: busy=0, done=0, addr_a=0, addr_b=0, we_b=0, data_b=0, state=IDLE.
- Reset asserted mid-copy aborts immediately: we_b drops asynchronously, no done pulse is issued, and words already written stay in the RAM.
- RAM timing contract: the RAM samples address and write enable on the rising edge; q_a_out is valid in the cycle after addr_a was presented. This is one cycle of read latency.

State machine:
- IDLE:
  - start=1 with len=0 → DONE; no RAM access occurs.
  - start=1 with len>0 → latch operands and go to READ. busy=1 from the next cycle.
  - start=0 → stay in IDLE.
- READ: issue one read per cycle for len cycles.
  - Read index i (0..len-1) appears on addr_a in READ cycle i.
  - The write for index i is issued in the following cycle: addr_b = destination address of i, data_b = q_a_out, we_b=1.
- FLUSH: single cycle that issues the last write (we_b=1); then → DONE.
- DONE: done=1 for one cycle, busy=0, then → IDLE.

Direction selection:
- Computed once at start: diff = (dst_addr - src_addr) mod 2^ADDR_WIDTH.
- If 1 ≤ diff ≤ len-1 the copy is DESCENDING: index i accesses src+len-1-i and dst+len-1-i.
- Otherwise the copy is ASCENDING: index i accesses src+i and dst+i.
- This rule guarantees a source word is never read after it has been overwritten, including the same-cycle read/write collision case.

Timing and boundary rules:
- Total latency from the accepted start edge to done high is len+2 cycles for len>0, and 1 cycle for len=0.
- All address arithmetic wraps modulo 2^ADDR_WIDTH; e.g. src=1022, len=4 reads 1022, 1023, 0, 1.
- len=1024 copies the whole memory. diff=0 (src=dst) uses ASCENDING and rewrites identical data.
- start while busy or in DONE is ignored; it is not queued.
- Operand inputs are don't-care except in the start cycle.
- we_b is never high in IDLE or DONE. addr_a holds its last value when not reading.
- data_b is combinational from q_a_out and is gated to 0 when we_b=0.

Decomposition:
- Shared package ram_pkg holds:
  - DATA_WIDTH=16 and ADDR_WIDTH=10 constants.
  - The state encoding IDLE/READ/FLUSH/DONE.
  - The direction enum ASC/DESC.
- One natural sub-module, ram_copy_addr_gen: takes base, len, direction and index, and produces a wrapped address. It is instantiated twice, once for the source and once for the destination (destination index lags by one cycle).
- Everything else lives in the top module: FSM, index counter, direction compare.

Test Plan:
- Basic copy: preload RAM[13..16]=3,4,5,6; start src=13 dst=47 len=4 → RAM[47..50]=3,4,5,6. done pulses exactly 6 cycles after start; we_b high for 4 cycles.
- Forward overlap: RAM[100..104]=1..5; src=100 dst=102 len=5 → DESCENDING; RAM[102..106]=1,2,3,4,5; first addr_a=104.
- Backward overlap: RAM[200..203]=9,8,7,6; src=200 dst=199 len=4 → ASCENDING; RAM[199..202]=9,8,7,6; RAM[203]=6 unchanged.
- Wrap-around: RAM[1022,1023,0,1]=43,44,45,46; src=1022 dst=500 len=4 → RAM[500..503]=43..46. Also src=500 dst=1023 len=2 writes addresses 1023 and 0.
- Edge cases:
  - len=0 → done one cycle after start; we_b never high.
  - start pulsed during a busy copy → ignored; the original copy completes unchanged.
- Reset mid-copy: len=8, assert rst_n=0 at READ cycle 3 → we_b=0 and busy=0 immediately; no done pulse; RAM[dst+0..dst+1] written and dst+2.. untouched. A subsequent start operates normally.
